rom_sequencer: RTL and testbench

- Parametrised, synchronous-read ROM with a built-in playback engine for the VGA test path.
- Holds NUM_PAGES pages of DEPTH entries each, for example one command/glyph sequence per digit.
- On a start request it streams the selected page out over a valid/ready interface. It stops at a terminator value or at the page end, and can optionally loop.
- Sits between the test-pattern controller (start/page/loop) and the drawing logic (stream consumer).

---
 rtl/rom_sequencer.sv | 154 +++++++++++++++
 tb/tb_rom_sequencer.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/rom_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : rom_sequencer
// Brief    : Paged synchronous-read ROM with a valid/ready playback engine that
//            stops on a terminator entry or at the page end, optionally looping.
// Revision : 1.0 - initial release
// ============================================================================
module rom_sequencer #(
    parameter int                                      DATA_W    = 8,
    parameter int                                      ADDR_W    = 4,
    parameter int                                      NUM_PAGES = 10,
    parameter int                                      PAGE_W    = 4,
    parameter int                                      TERM_EN   = 1,
    parameter logic [DATA_W-1:0]                       TERM_VAL  = '0,
    parameter logic [NUM_PAGES*(2**ADDR_W)*DATA_W-1:0] INIT_DATA = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [PAGE_W-1:0] page,
    input  logic              loop,
    input  logic              abort,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    output logic              busy,
    output logic              done,
    output logic              err
);
    localparam int                c_depth     = 2**ADDR_W;
    localparam int                c_words     = NUM_PAGES*c_depth;
    localparam logic [ADDR_W-1:0] c_last_off  = '1;
    localparam logic [PAGE_W:0]   c_num_pages = (PAGE_W+1)'(NUM_PAGES);

    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_fetch = 2'd1;
    localparam logic [1:0] c_st_emit  = 2'd2;

    logic [1:0]        r_state;
    logic [PAGE_W-1:0] r_page;
    logic              r_loop;
    logic [ADDR_W-1:0] r_offset;
    logic              r_valid;
    logic [DATA_W-1:0] r_data;
    logic              r_last;
    logic              r_busy;
    logic              r_done;
    logic              r_err;

    logic [DATA_W-1:0]        w_rom [c_words];
    logic [ADDR_W-1:0]        w_rd_off;
    logic [PAGE_W+ADDR_W-1:0] w_addr;
    logic [DATA_W-1:0]        w_rd;
    logic                     w_hs;
    logic                     w_at_end;
    logic                     w_rd_en;
    logic                     w_term;
    logic                     w_seq_end;

    genvar gi;
    generate
        for (gi = 0; gi < c_words; gi++) begin : g_rom
            assign w_rom[gi] = INIT_DATA[gi*DATA_W +: DATA_W];
        end
    endgenerate

    // FETCH reads the current offset; a handshake in EMIT prefetches the next.
    assign w_rd_off  = (r_state == c_st_emit) ? r_offset + ADDR_W'(1) : r_offset;
    assign w_addr    = {r_page, w_rd_off};
    assign w_rd      = w_rom[w_addr];
    assign w_hs      = r_valid & out_ready;
    assign w_at_end  = (r_offset == c_last_off);
    assign w_rd_en   = (r_state == c_st_fetch) ||
                       ((r_state == c_st_emit) && w_hs && !w_at_end);
    assign w_term    = (TERM_EN != 0) && (w_rd == TERM_VAL);
    assign w_seq_end = (w_rd_en && w_term) ||
                       ((r_state == c_st_emit) && w_hs && w_at_end);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= c_st_idle;
            r_page   <= '0;
            r_loop   <= 1'b0;
            r_offset <= '0;
            r_valid  <= 1'b0;
            r_data   <= '0;
            r_last   <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            if (abort) begin
                r_state  <= c_st_idle;
                r_offset <= '0;
                r_valid  <= 1'b0;
                r_last   <= 1'b0;
                r_busy   <= 1'b0;
            end else begin
                case (r_state)
                    c_st_idle: begin
                        if (start) begin
                            if ({1'b0, page} < c_num_pages) begin
                                r_page   <= page;
                                r_loop   <= loop;
                                r_offset <= '0;
                                r_busy   <= 1'b1;
                                r_state  <= c_st_fetch;
                            end else begin
                                r_err <= 1'b1;
                            end
                        end
                    end
                    c_st_fetch, c_st_emit: begin
                        if (w_seq_end) begin
                            r_valid  <= 1'b0;
                            r_last   <= 1'b0;
                            r_offset <= '0;
                            if (r_loop) begin
                                r_state <= c_st_fetch;
                            end else begin
                                r_state <= c_st_idle;
                                r_busy  <= 1'b0;
                                r_done  <= 1'b1;
                            end
                        end else if (w_rd_en) begin
                            r_data   <= w_rd;
                            r_valid  <= 1'b1;
                            r_last   <= (w_rd_off == c_last_off);
                            r_offset <= w_rd_off;
                            r_state  <= c_st_emit;
                        end
                    end
                    default: begin
                        r_state <= c_st_idle;
                        r_valid <= 1'b0;
                        r_busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign out_valid = r_valid;
    assign out_data  = r_data;
    assign out_last  = r_last;
    assign busy      = r_busy;
    assign done      = r_done;
    assign err       = r_err;

endmodule
`default_nettype wire

// File: tb/tb_rom_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_rom_sequencer
// Brief    : Table-driven and directed bench for rom_sequencer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rom_sequencer;
    // Entry 0 of each page sits in the least significant byte.
    localparam logic [127:0]  c_pg0 = 128'h0000_0000_0000_2625_2423_2221_F110_0202;
    localparam logic [127:0]  c_pg1 = 128'h403F_3E3D_3C3B_3A39_3837_3635_3433_3231;
    localparam logic [127:0]  c_pg2 = 128'h5555_5555_5555_5555_5555_5555_5555_5500;
    localparam logic [127:0]  c_pg9 = 128'h0000_0000_0000_0000_0000_0000_0000_A1A0;
    localparam logic [1279:0] c_rom = {c_pg9, 768'h0, c_pg2, c_pg1, c_pg0};

    logic       clk = 1'b0;
    logic       rst_n, start, loop, abort, out_ready;
    logic [3:0] page;

    logic       w_valid_a, w_last_a, w_busy_a, w_done_a, w_err_a;
    logic [7:0] w_data_a;
    logic       w_valid_b, w_last_b, w_busy_b, w_done_b, w_err_b;
    logic [7:0] w_data_b;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] q_data[$];
    logic       q_last[$];
    logic [7:0] eq_data[$];
    logic       eq_last[$];

    typedef struct {
        logic       st;
        logic [3:0] pg;
        logic       ab;
        logic       rn;
        logic       ev;
        logic [7:0] ed;
        logic       eb;
        logic       edn;
        logic       eer;
        logic       cd;
    } vec_t;

    vec_t tbl[$];

    rom_sequencer #(
        .DATA_W(8), .ADDR_W(4), .NUM_PAGES(10), .PAGE_W(4),
        .TERM_EN(1), .TERM_VAL(8'h00), .INIT_DATA(c_rom)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .page(page), .loop(loop),
        .abort(abort), .out_valid(w_valid_a), .out_ready(out_ready),
        .out_data(w_data_a), .out_last(w_last_a), .busy(w_busy_a),
        .done(w_done_a), .err(w_err_a)
    );

    rom_sequencer #(
        .DATA_W(8), .ADDR_W(4), .NUM_PAGES(10), .PAGE_W(4),
        .TERM_EN(0), .TERM_VAL(8'h00), .INIT_DATA(c_rom)
    ) dut_noterm (
        .clk(clk), .rst_n(rst_n), .start(start), .page(page), .loop(loop),
        .abort(abort), .out_valid(w_valid_b), .out_ready(out_ready),
        .out_data(w_data_b), .out_last(w_last_b), .busy(w_busy_b),
        .done(w_done_b), .err(w_err_b)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic st, input int pg, input logic ab, input logic rn,
                                input logic ev, input logic [7:0] ed, input logic eb,
                                input logic edn, input logic eer, input logic cd);
        vec_t r;
        r.st = st; r.pg = pg[3:0]; r.ab = ab; r.rn = rn;
        r.ev = ev; r.ed = ed; r.eb = eb; r.edn = edn; r.eer = eer; r.cd = cd | ev;
        return r;
    endfunction

    function automatic vec_t beat(input logic [7:0] d);
        return mk(1'b0, 0, 1'b0, 1'b1, 1'b1, d, 1'b1, 1'b0, 1'b0, 1'b0);
    endfunction

    function automatic vec_t quiet();
        return mk(1'b0, 0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    endfunction

    // Reference playback: entries up to a terminator (if enabled) or the page end.
    function automatic void build_exp(input int pg, input bit term_en);
        logic [7:0] d;
        eq_data.delete();
        eq_last.delete();
        for (int o = 0; o < 16; o++) begin
            d = c_rom[(pg*16 + o)*8 +: 8];
            if (term_en && d == 8'h00) break;
            eq_data.push_back(d);
            eq_last.push_back(o == 15);
        end
    endfunction

    task automatic cmp_beats(input string tag);
        chk({tag, "_count"}, q_data.size(), eq_data.size());
        for (int i = 0; i < eq_data.size() && i < q_data.size(); i++)
            chk($sformatf("%s_beat%0d", tag, i), {q_last[i], q_data[i]}, {eq_last[i], eq_data[i]});
    endtask

    // mode 0: out_ready held high; mode 1: out_ready pattern 1,0,0,1,0,0...
    task automatic play(input int pg, input int mode, input bit which, output int done_cyc);
        logic       v, l, dn;
        logic [7:0] d, prev_d;
        bit         stalled;
        q_data.delete();
        q_last.delete();
        done_cyc = -1;
        stalled  = 0;
        prev_d   = '0;
        @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0; start = 1'b1; page = 4'(pg); loop = 1'b0;
        for (int c = 0; c < 60 && done_cyc < 0; c++) begin
            if (c > 0) @(negedge clk);
            if (c == 1) start = 1'b0;
            out_ready = (mode == 0) || (c % 3 == 0);
            v  = which ? w_valid_b : w_valid_a;
            d  = which ? w_data_b  : w_data_a;
            l  = which ? w_last_b  : w_last_a;
            dn = which ? w_done_b  : w_done_a;
            if (stalled) chk($sformatf("stall_hold_c%0d", c), {v, d}, {1'b1, prev_d});
            if (v && out_ready) begin
                q_data.push_back(d);
                q_last.push_back(l);
            end
            stalled = v && !out_ready;
            prev_d  = d;
            if (dn) done_cyc = c;
        end
        start = 1'b0;
        chk("done_seen", (done_cyc >= 0), 1'b1);
        @(negedge clk);
        chk("done_one_cycle", which ? w_done_b : w_done_a, 1'b0);
    endtask

    initial begin
        logic [12:0] act, exp;
        int          dc, nd;

        rst_n = 1'b0; start = 1'b0; page = '0; loop = 1'b0; abort = 1'b0; out_ready = 1'b1;

        tbl.push_back(mk(0, 0, 0, 1, 0, 8'h00, 0, 0, 0, 1));   // reset state
        tbl.push_back(mk(1, 12, 0, 1, 0, 8'h00, 0, 0, 0, 0));  // invalid page
        tbl.push_back(mk(0, 0, 0, 1, 0, 8'h00, 0, 0, 1, 0));   // err pulse
        tbl.push_back(mk(1, 0, 1, 1, 0, 8'h00, 0, 0, 0, 0));   // start with abort
        tbl.push_back(quiet());
        tbl.push_back(mk(1, 0, 0, 1, 0, 8'h00, 0, 0, 0, 0));   // play page 0
        tbl.push_back(mk(0, 0, 0, 1, 0, 8'h00, 1, 0, 0, 0));   // fetch
        tbl.push_back(beat(8'h02));
        tbl.push_back(mk(1, 12, 0, 1, 1, 8'h02, 1, 0, 0, 0));  // start while busy
        tbl.push_back(beat(8'h10));
        tbl.push_back(beat(8'hF1));
        for (int i = 0; i < 6; i++) tbl.push_back(beat(8'h21 + 8'(i)));
        tbl.push_back(mk(0, 0, 0, 1, 0, 8'h00, 0, 1, 0, 0));   // done after terminator
        tbl.push_back(quiet());
        tbl.push_back(mk(1, 0, 0, 1, 0, 8'h00, 0, 0, 0, 0));   // replay, reset mid-stream
        tbl.push_back(mk(0, 0, 0, 1, 0, 8'h00, 1, 0, 0, 0));
        tbl.push_back(beat(8'h02));
        tbl.push_back(beat(8'h02));
        tbl.push_back(beat(8'h10));
        tbl.push_back(beat(8'hF1));
        tbl.push_back(mk(0, 0, 0, 0, 1, 8'h21, 1, 0, 0, 0));   // rst_n low on beat 5
        tbl.push_back(mk(0, 0, 0, 1, 0, 8'h00, 0, 0, 0, 1));   // everything cleared
        tbl.push_back(mk(1, 0, 0, 1, 0, 8'h00, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 1, 0, 8'h00, 1, 0, 0, 0));
        tbl.push_back(beat(8'h02));
        tbl.push_back(beat(8'h02));
        tbl.push_back(mk(0, 0, 1, 1, 1, 8'h10, 1, 0, 0, 0));   // abort mid-stream
        tbl.push_back(quiet());
        tbl.push_back(quiet());

        repeat (3) @(negedge clk);
        for (int k = 0; k < tbl.size(); k++) begin
            @(negedge clk);
            act = {w_valid_a, w_last_a, w_busy_a, w_done_a, w_err_a, tbl[k].cd ? w_data_a : 8'h00};
            exp = {tbl[k].ev, 1'b0, tbl[k].eb, tbl[k].edn, tbl[k].eer, tbl[k].cd ? tbl[k].ed : 8'h00};
            chk($sformatf("vec%0d", k), act, exp);
            start = tbl[k].st; page = tbl[k].pg; abort = tbl[k].ab; rst_n = tbl[k].rn;
            loop = 1'b0; out_ready = 1'b1;
        end

        // Full page without terminator: 16 beats, last only on the final one.
        play(1, 0, 1'b0, dc);
        build_exp(1, 1'b1);
        cmp_beats("page1");
        chk("page1_done_cycle", dc, 18);

        // Terminator disabled: trailing zero entries are emitted.
        play(0, 0, 1'b1, dc);
        build_exp(0, 1'b0);
        cmp_beats("noterm");
        chk("noterm_done_cycle", dc, 18);

        // Backpressure must not drop, duplicate or alter beats.
        play(0, 1, 1'b0, dc);
        build_exp(0, 1'b1);
        cmp_beats("bp");

        // Terminator at offset 0: no beats, done two cycles after start.
        play(2, 0, 1'b0, dc);
        build_exp(2, 1'b1);
        cmp_beats("empty");
        chk("empty_done_cycle", dc, 2);

        play(9, 0, 1'b0, dc);
        build_exp(9, 1'b1);
        cmp_beats("page9");
        chk("page9_done_cycle", dc, 4);

        // Looping playback with an abort in the second pass.
        q_data.delete();
        q_last.delete();
        nd = 0;
        @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0; start = 1'b1; page = 4'd0; loop = 1'b1; out_ready = 1'b1;
        for (int c = 0; c <= 20; c++) begin
            if (c > 0) @(negedge clk);
            if (c == 1) begin start = 1'b0; loop = 1'b0; end
            if (c == 18) abort = 1'b1;
            if (c == 19) abort = 1'b0;
            if (w_valid_a && out_ready) begin
                q_data.push_back(w_data_a);
                q_last.push_back(w_last_a);
            end
            if (w_done_a) nd++;
            if (c == 12) chk("loop_bubble", {w_valid_a, w_busy_a}, 2'b01);
            if (c == 19) chk("loop_abort_next", {w_valid_a, w_busy_a, w_done_a}, 3'b000);
        end
        build_exp(0, 1'b1);
        for (int i = 0; i < 6; i++) begin
            eq_data.push_back(eq_data[i]);
            eq_last.push_back(1'b0);
        end
        cmp_beats("loop");
        chk("loop_no_done", nd, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1);
    end
endmodule
`default_nettype wire
